prmcu_uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver for the prmcu UART path, the receive-side successor to `prmcu_uart_top`'s fixed RX. It synchronises `rx_i`, detects start bits with 16x (parametrisable) oversampling and 3-sample majority vote, and deframes 5–9 data bits with none/even/odd parity and 1–2 stop bits. Each frame is pushed with error flags into an internal FIFO drained over a valid/ready interface.

---
 rtl/prmcu_uart_pkg.sv | 43 ++++
 rtl/prmcu_uart_rx_fifo.sv | 52 +++++
 rtl/prmcu_uart_rx_os.sv | 224 ++++++++++++++++++++++
 tb/tb_prmcu_uart_rx_os.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prmcu_uart_pkg.sv
// prmcu_uart_pkg
// Shared types and constants for the prmcu UART receive path.
//   parity_mode_t    : latched parity configuration
//   uart_rx_state_t  : receiver framing FSM states
//   ERR_*            : bit positions inside the 3-bit error flag field
package prmcu_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_rx_state_t;

  localparam int unsigned ERR_PARITY = 0;
  localparam int unsigned ERR_FRAME  = 1;
  localparam int unsigned ERR_BREAK  = 2;

  // Encoding 11 is reserved and behaves as "no parity".
  function automatic parity_mode_t decode_parity(input logic [1:0] m);
    case (m)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Data bit count limited to 5..hi.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] n,
                                                  input logic [3:0] hi);
    if (n < 4'd5) return 4'd5;
    if (n > hi)   return hi;
    return n;
  endfunction

endpackage

// File: rtl/prmcu_uart_rx_fifo.sv
// prmcu_uart_rx_fifo
// Synchronous first-word-fall-through FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_dat  : write request and data (write while full is accepted
//                     only when a pop happens in the same cycle)
//   pop             : read request, ignored when empty
//   pop_dat         : head entry, 0 while empty
//   full, empty     : occupancy status
module prmcu_uart_rx_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/prmcu_uart_rx_os.sv
// prmcu_uart_rx_os
// Oversampling UART receiver with 3-sample majority vote, 5..9 data bits,
// none/even/odd parity, 1..2 stop bits and a receive FIFO.
//   clk, rst                 : clock, synchronous active-high reset
//   rx_en                    : receiver enable (drop aborts the current frame)
//   parity_mode_i            : 00 none, 01 even, 10 odd, 11 none
//   n_stop_bits_i            : 0/1 -> one stop bit, 2/3 -> two
//   n_data_bits_i            : clamped to 5..9
//   clk_divider_i            : oversample tick every clk_divider_i+1 cycles
//   rx_i                     : asynchronous serial line, idle high
//   out_dat_o/out_err_o      : FIFO head data / {break, frame, parity}
//   out_vld_o/out_rdy_i      : FIFO valid/ready drain interface
//   overrun_o                : pulse when a completed frame is dropped
//   busy_o                   : a frame is in progress
module prmcu_uart_rx_os
  import prmcu_uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OS         = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_en,
  input  logic [1:0]        parity_mode_i,
  input  logic [1:0]        n_stop_bits_i,
  input  logic [3:0]        n_data_bits_i,
  input  logic [DIV_W-1:0]  clk_divider_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] out_dat_o,
  output logic [2:0]        out_err_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int unsigned OS_W = $clog2(OS);
  localparam logic [OS_W-1:0] SMP_A   = OS_W'(OS/2 - 1);
  localparam logic [OS_W-1:0] SMP_B   = OS_W'(OS/2);
  localparam logic [OS_W-1:0] SMP_C   = OS_W'(OS/2 + 1);
  localparam logic [OS_W-1:0] BIT_END = OS_W'(OS - 1);
  localparam logic [3:0] MAX_BITS = (DATA_W < 9) ? 4'(DATA_W) : 4'd9;

  uart_rx_state_t    state;
  parity_mode_t      cfg_par;
  logic              cfg_two_stop;
  logic [3:0]        cfg_nbits;
  logic [3:0]        bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] data;
  logic              par_bit, par_err, frame_err;
  logic              push_req;
  logic [DATA_W+2:0] push_ent;

  logic              rx_meta, rxs, rxs_prev;
  logic              fall, start_det;
  logic [DIV_W-1:0]  presc;
  logic              tick;
  logic [OS_W-1:0]   os_cnt;
  logic              s_a, s_b, vote, mid, bit_end;
  logic              frame_now, brk_now;
  logic [2:0]        push_flags;

  logic [DATA_W+2:0] head;
  logic              fifo_full, fifo_empty, pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx_i;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign fall      = rxs_prev & ~rxs;
  assign start_det = (state == S_IDLE) && rx_en && fall;

  assign tick = (presc == clk_divider_i);

  // Both timebases restart on the start edge so sampling is phase-aligned
  // to the falling edge of the start bit.
  always_ff @(posedge clk) begin
    if (rst || start_det) begin
      presc  <= '0;
      os_cnt <= '0;
    end else if (tick) begin
      presc  <= '0;
      os_cnt <= (os_cnt == BIT_END) ? '0 : os_cnt + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (tick && os_cnt == SMP_A) s_a <= rxs;
      if (tick && os_cnt == SMP_B) s_b <= rxs;
    end
  end

  // Third vote sample is the live line at the mid tick.
  assign mid     = tick && (os_cnt == SMP_C);
  assign bit_end = tick && (os_cnt == BIT_END);
  assign vote    = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);

  assign frame_now = frame_err | ~vote;
  assign brk_now   = frame_now && (data == '0) && !par_bit;

  always_comb begin
    push_flags             = '0;
    push_flags[ERR_PARITY] = par_err;
    push_flags[ERR_FRAME]  = frame_now;
    push_flags[ERR_BREAK]  = brk_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cfg_par      <= PAR_NONE;
      cfg_two_stop <= 1'b0;
      cfg_nbits    <= 4'd8;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      data         <= '0;
      par_bit      <= 1'b0;
      par_err      <= 1'b0;
      frame_err    <= 1'b0;
      push_req     <= 1'b0;
      push_ent     <= '0;
    end else begin
      push_req <= 1'b0;
      if (!rx_en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (fall) begin
              state        <= S_START;
              cfg_par      <= decode_parity(parity_mode_i);
              cfg_two_stop <= n_stop_bits_i[1];
              cfg_nbits    <= clamp_data_bits(n_data_bits_i, MAX_BITS);
              bit_idx      <= '0;
              stop_idx     <= 1'b0;
              data         <= '0;
              par_bit      <= 1'b0;
              par_err      <= 1'b0;
              frame_err    <= 1'b0;
            end
          end
          S_START: begin
            if (mid && vote)  state <= S_IDLE;
            else if (bit_end) state <= S_DATA;
          end
          S_DATA: begin
            if (mid) data[bit_idx] <= vote;
            if (bit_end) begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == cfg_nbits - 4'd1)
                state <= (cfg_par == PAR_NONE) ? S_STOP : S_PARITY;
            end
          end
          S_PARITY: begin
            if (mid) begin
              par_bit <= vote;
              par_err <= ((^data) ^ vote) != (cfg_par == PAR_ODD);
            end
            if (bit_end) state <= S_STOP;
          end
          S_STOP: begin
            // The last stop bit ends at its mid-sample so a start edge
            // immediately following it is still caught.
            if (mid) begin
              frame_err <= frame_now;
              if (stop_idx == cfg_two_stop) begin
                push_req <= 1'b1;
                push_ent <= {push_flags, data};
                state    <= S_IDLE;
              end
            end else if (bit_end) begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign pop = out_vld_o && out_rdy_i;

  prmcu_uart_rx_fifo #(
    .WIDTH (DATA_W + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) overrun_o <= 1'b0;
    else     overrun_o <= push_req && fifo_full && !pop;
  end

  assign out_vld_o = !fifo_empty;
  assign out_dat_o = head[DATA_W-1:0];
  assign out_err_o = head[DATA_W+2:DATA_W];
  assign busy_o    = (state != S_IDLE);

endmodule

// File: tb/tb_prmcu_uart_rx_os.sv
module tb_prmcu_uart_rx_os;

  localparam int BIT = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_en;
  logic [1:0]  parity_mode_i;
  logic [1:0]  n_stop_bits_i;
  logic [3:0]  n_data_bits_i;
  logic [15:0] clk_divider_i;
  logic        rx_i;
  logic [8:0]  out_dat_o;
  logic [2:0]  out_err_o;
  logic        out_vld_o;
  logic        out_rdy_i;
  logic        overrun_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt  = 0;
  int rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;

  always #5 clk = ~clk;

  prmcu_uart_rx_os #(
    .DATA_W     (9),
    .DIV_W      (16),
    .OS         (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_en         (rx_en),
    .parity_mode_i (parity_mode_i),
    .n_stop_bits_i (n_stop_bits_i),
    .n_data_bits_i (n_data_bits_i),
    .clk_divider_i (clk_divider_i),
    .rx_i          (rx_i),
    .out_dat_o     (out_dat_o),
    .out_err_o     (out_err_o),
    .out_vld_o     (out_vld_o),
    .out_rdy_i     (out_rdy_i),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected FIFO entry {break, frame, parity, data} derived from what was
  // put on the line.
  function automatic logic [11:0] model_frame(input int nb, input int pm,
                                              input logic [8:0] d, input logic pbit,
                                              input logic [1:0] stops, input int nst);
    logic [8:0] dm;
    logic perr, ferr, brk, has_par;
    int ones;
    dm = d & 9'((1 << nb) - 1);
    has_par = (pm == 1) || (pm == 2);
    ones = $countones(dm) + int'(pbit);
    perr = 1'b0;
    if (pm == 1) perr = (ones % 2) != 0;
    if (pm == 2) perr = (ones % 2) != 1;
    ferr = !stops[0] || (nst == 2 && !stops[1]);
    brk  = ferr && (dm == 9'd0) && !(has_par && pbit);
    return {brk, ferr, perr, dm};
  endfunction

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] nb_in, input logic [1:0] pm_in,
                            input logic [1:0] ns_in, input logic [8:0] d,
                            input bit bad_par, input logic [1:0] stops,
                            input bit expect_push);
    int nb, pm, nst;
    logic [8:0] dm;
    logic pbit;
    parity_mode_i = pm_in;
    n_stop_bits_i = ns_in;
    n_data_bits_i = nb_in;
    nb  = (nb_in < 5) ? 5 : (nb_in > 9) ? 9 : int'(nb_in);
    pm  = int'(pm_in);
    nst = (ns_in >= 2) ? 2 : 1;
    dm  = d & 9'((1 << nb) - 1);
    pbit = (pm == 2) ? ~(^dm) : (^dm);
    if (bad_par) pbit = ~pbit;
    if (!(pm == 1 || pm == 2)) pbit = 1'b0;
    if (expect_push) exp_q.push_back(model_frame(nb, pm, d, pbit, stops, nst));
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pm == 1 || pm == 2) drive_bit(pbit);
    for (int i = 0; i < nst; i++) drive_bit(stops[i]);
    rx_i = 1'b1;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 4000) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Consumer-side scoreboard: every handshake must match the next expected entry.
  always @(negedge clk) begin
    if (overrun_o) ovr_cnt++;
    if (!rst && out_vld_o && out_rdy_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_vld", 32'(out_vld_o), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_data", 32'(out_dat_o), 32'(mon_e[8:0]));
        chk("rx_flags", 32'(out_err_o), 32'(mon_e[11:9]));
      end
    end
  end

  // Ready changes just after the rising edge so the negedge view is stable.
  initial begin
    out_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_rdy_i = 1'b0;
        1:       out_rdy_i = 1'b1;
        default: out_rdy_i = 1'($urandom_range(1, 0));
      endcase
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr_base, i;
    logic [3:0] nb;
    logic [1:0] pm, ns, st;
    logic [8:0] d;
    bit bp;

    rst = 1'b1;
    rx_en = 1'b1;
    rx_i = 1'b1;
    parity_mode_i = 2'b00;
    n_stop_bits_i = 2'd1;
    n_data_bits_i = 4'd8;
    clk_divider_i = 16'd4;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(out_vld_o), 0);
    chk("rst_dat", 32'(out_dat_o), 0);
    chk("rst_err", 32'(out_err_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst = 1'b0;
    idle(20);

    // 8N1 back-to-back
    send_frame(4'd8, 2'b00, 2'd1, 9'h0A5, 0, 2'b11, 1);
    send_frame(4'd8, 2'b00, 2'd1, 9'h03C, 0, 2'b11, 1);
    idle(2 * BIT);
    wait_drain();

    // 7E2 with bad parity, then 9O1 good
    send_frame(4'd7, 2'b01, 2'd2, 9'h055, 1, 2'b11, 1);
    send_frame(4'd9, 2'b10, 2'd1, 9'h1FF, 0, 2'b11, 1);
    idle(2 * BIT);
    wait_drain();

    // Break: 20 bit times low under 8N1
    parity_mode_i = 2'b00;
    n_stop_bits_i = 2'd1;
    n_data_bits_i = 4'd8;
    exp_q.push_back({3'b110, 9'h000});
    rx_i = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    #1;
    idle(3 * BIT);
    wait_drain();

    // 30-clk glitch
    rx_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_rise", 32'(busy_o), 1);
    repeat (23) @(posedge clk);
    #1;
    rx_i = 1'b1;
    i = 0;
    while (busy_o && i < 30) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("glitch_busy_fall", 32'(busy_o), 0);
    idle(2 * BIT);
    chk("glitch_no_push", 32'(out_vld_o), 0);

    // Overrun: FIFO_DEPTH+1 frames with the consumer stalled
    rdy_mode = 0;
    idle(5);
    ovr_base = ovr_cnt;
    for (int k = 0; k < 5; k++)
      send_frame(4'd8, 2'b00, 2'd1, 9'($urandom_range(255, 0)), 0, 2'b11, k < 4);
    idle(BIT);
    chk("ovr_vld", 32'(out_vld_o), 1);
    chk("ovr_pulses", ovr_cnt - ovr_base, 1);
    rdy_mode = 1;
    wait_drain();

    // rx_en dropped mid-frame
    fork
      send_frame(4'd8, 2'b00, 2'd1, 9'h05A, 0, 2'b11, 0);
      begin
        repeat (4 * BIT) @(posedge clk);
        @(negedge clk);
        chk("en_busy_before", 32'(busy_o), 1);
        rx_en = 1'b0;
        @(negedge clk);
        chk("en_busy_after", 32'(busy_o), 0);
      end
    join
    idle(BIT);
    rx_en = 1'b1;
    idle(20);
    chk("en_no_push", 32'(out_vld_o), 0);
    send_frame(4'd8, 2'b00, 2'd1, 9'h0C3, 0, 2'b11, 1);
    idle(BIT);
    wait_drain();

    // Randomized frames with random configuration and consumer stalls
    rdy_mode = 2;
    ovr_base = ovr_cnt;
    for (int k = 0; k < 30; k++) begin
      nb = 4'($urandom_range(11, 3));
      pm = 2'($urandom_range(3, 0));
      ns = 2'($urandom_range(3, 0));
      d  = 9'($urandom_range(511, 0));
      bp = ($urandom_range(3, 0) == 0);
      st = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b11;
      if ($urandom_range(7, 0) == 0) d = 9'h000;
      send_frame(nb, pm, ns, d, bp, st, 1);
      idle($urandom_range(40, 4));
    end
    idle(BIT);
    wait_drain();
    chk("rand_no_overrun", ovr_cnt - ovr_base, 0);
    rdy_mode = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
